// File: rtl/bsg_arb_round_robin_burst_if.sv
// Handshake bundle between requesters, the burst arbiter and the downstream channel.
interface bsg_arb_round_robin_burst_if #(
  parameter int els_p = 16
);
  localparam int ID_W = $clog2(els_p);

  logic [els_p-1:0] reqs_i;
  logic [els_p-1:0] last_i;
  logic             ready_i;
  logic [els_p-1:0] grants_o;
  logic [ID_W-1:0]  grant_id_o;
  logic             v_o;
  logic             yumi_o;
  logic             burst_end_o;

  // Requester/downstream side: drives requests and ready, observes grants.
  modport master (
    output reqs_i, last_i, ready_i,
    input  grants_o, grant_id_o, v_o, yumi_o, burst_end_o
  );

  // Arbiter side.
  modport slave (
    input  reqs_i, last_i, ready_i,
    output grants_o, grant_id_o, v_o, yumi_o, burst_end_o
  );
endinterface

// File: rtl/bsg_arb_round_robin_burst.sv
// Round-robin arbiter that locks the grant for a multi-beat burst.
// The lock releases on the owner's last beat or after max_beats_p beats;
// the previous winner only advances at burst end, so the owner of a burst
// gets the lowest priority in the next arbitration.
module bsg_arb_round_robin_burst #(
  parameter int els_p       = 16,
  parameter int max_beats_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  bsg_arb_round_robin_burst_if.slave   bus
);

  localparam int ID_W  = $clog2(els_p);
  localparam int CNT_W = $clog2(max_beats_p + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           r_state,    w_state_nxt;
  logic [ID_W-1:0]  r_last,     w_last_nxt;
  logic [ID_W-1:0]  r_lock_id,  w_lock_id_nxt;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;

  logic [ID_W-1:0]  w_win_m, w_win_a, w_win_id, w_sel_id;
  logic             w_hit_m, w_hit_a;
  logic             w_v, w_yumi, w_end;

  // Winner: lowest request above the previous winner, else lowest request overall.
  always_comb begin
    w_win_m = '0;
    w_win_a = '0;
    w_hit_m = 1'b0;
    w_hit_a = 1'b0;
    for (int unsigned i = 0; i < els_p; i++) begin
      if (!w_hit_m && bus.reqs_i[i] && (ID_W'(i) > r_last)) begin
        w_hit_m = 1'b1;
        w_win_m = ID_W'(i);
      end
      if (!w_hit_a && bus.reqs_i[i]) begin
        w_hit_a = 1'b1;
        w_win_a = ID_W'(i);
      end
    end
    w_win_id = w_hit_m ? w_win_m : w_win_a;
  end

  // State register; reset mid-burst simply abandons the lock.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_last     <= ID_W'(els_p - 1);
      r_lock_id  <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_lock_id  <= w_lock_id_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // Next state: registers only move on a transferred beat.
  always_comb begin
    w_state_nxt    = r_state;
    w_last_nxt     = r_last;
    w_lock_id_nxt  = r_lock_id;
    w_beat_cnt_nxt = r_beat_cnt;
    if (w_yumi) begin
      unique case (r_state)
        IDLE: begin
          if (w_end) begin
            w_last_nxt = w_win_id;
          end else begin
            w_state_nxt    = LOCK;
            w_lock_id_nxt  = w_win_id;
            w_beat_cnt_nxt = CNT_W'(1);
          end
        end
        LOCK: begin
          if (w_end) begin
            w_state_nxt    = IDLE;
            w_last_nxt     = r_lock_id;
            w_beat_cnt_nxt = '0;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: grant follows the winner in IDLE and the owner in LOCK; all forced low in reset.
  always_comb begin
    w_sel_id = (r_state == LOCK) ? r_lock_id : w_win_id;
    if (reset_i)
      w_v = 1'b0;
    else if (r_state == LOCK)
      w_v = bus.reqs_i[r_lock_id];
    else
      w_v = |bus.reqs_i;
    w_yumi = w_v & bus.ready_i;
    w_end  = bus.last_i[w_sel_id] | ((r_beat_cnt + 1'b1) == CNT_W'(max_beats_p));

    bus.v_o         = w_v;
    bus.yumi_o      = w_yumi;
    bus.burst_end_o = w_yumi & w_end;
    bus.grant_id_o  = w_v ? w_sel_id : '0;
    bus.grants_o    = w_v ? (els_p'(1) << w_sel_id) : '0;
  end

endmodule

// File: tb/tb_bsg_arb_round_robin_burst.sv
module tb_bsg_arb_round_robin_burst;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  bsg_arb_round_robin_burst_if #(.els_p(16)) bus ();

  bsg_arb_round_robin_burst #(.els_p(16), .max_beats_p(8)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  // Hold reset across a clock edge, then release at a negedge with the given inputs.
  task automatic reset_then(input logic [15:0] reqs, input logic [15:0] last, input logic ready);
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    bus.reqs_i  = reqs;
    bus.last_i  = last;
    bus.ready_i = ready;
    reset_i     = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.reqs_i = 16'hFFFF; bus.last_i = 16'hFFFF; bus.ready_i = 1'b1; reset_i = 1'b1;
    #1;
    n_vec++; if (bus.v_o !== 1'b0) begin n_err++; $display("FAIL reset_v got %b want 0", bus.v_o); end
    n_vec++; if (bus.grants_o !== 16'h0) begin n_err++; $display("FAIL reset_grants got %h want 0000", bus.grants_o); end
    n_vec++; if (bus.yumi_o !== 1'b0) begin n_err++; $display("FAIL reset_yumi got %b want 0", bus.yumi_o); end
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    for (int k = 0; k < 17; k++) begin
      n_vec++; if (bus.grant_id_o !== 4'(k % 16)) begin n_err++; $display("FAIL sweep_id k=%0d got %0d want %0d", k, bus.grant_id_o, k % 16); end
      n_vec++; if (bus.grants_o !== (16'h1 << (k % 16))) begin n_err++; $display("FAIL sweep_grants k=%0d got %h", k, bus.grants_o); end
      n_vec++; if (bus.burst_end_o !== 1'b1) begin n_err++; $display("FAIL sweep_end k=%0d got %b want 1", k, bus.burst_end_o); end
      @(negedge clk_i); #1;
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_id [4];
    exp_id = '{4'd0, 4'd15, 4'd0, 4'd15};
    reset_then(16'h8001, 16'hFFFF, 1'b1);
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (bus.grant_id_o !== exp_id[k]) begin n_err++; $display("FAIL rot_id k=%0d got %0d want %0d", k, bus.grant_id_o, exp_id[k]); end
      @(negedge clk_i); #1;
    end
  endtask

  task automatic test_burst_lock();
    reset_then(16'h0006, 16'h0000, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) begin bus.last_i = 16'h0002; #1; end
      n_vec++; if (bus.grant_id_o !== 4'd1) begin n_err++; $display("FAIL lock_id beat=%0d got %0d want 1", k, bus.grant_id_o); end
      n_vec++; if (bus.burst_end_o !== (k == 3)) begin n_err++; $display("FAIL lock_end beat=%0d got %b want %b", k, bus.burst_end_o, k == 3); end
      @(negedge clk_i); #1;
    end
    bus.last_i = 16'h0000; #1;
    n_vec++; if (bus.grant_id_o !== 4'd2) begin n_err++; $display("FAIL lock_next got %0d want 2", bus.grant_id_o); end
  endtask

  task automatic test_forced_release();
    reset_then(16'h0220, 16'h0000, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      n_vec++; if (bus.grant_id_o !== 4'd5) begin n_err++; $display("FAIL force_id beat=%0d got %0d want 5", k, bus.grant_id_o); end
      n_vec++; if (bus.burst_end_o !== (k == 8)) begin n_err++; $display("FAIL force_end beat=%0d got %b want %b", k, bus.burst_end_o, k == 8); end
      @(negedge clk_i); #1;
    end
    n_vec++; if (bus.grant_id_o !== 4'd9) begin n_err++; $display("FAIL force_next got %0d want 9", bus.grant_id_o); end
  endtask

  task automatic test_backpressure();
    reset_then(16'h0006, 16'h0000, 1'b1);
    @(negedge clk_i); #1;   // beat 1 transferred
    @(negedge clk_i);       // beat 2 transferred, count = 2
    bus.ready_i = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (bus.v_o !== 1'b1 || bus.grant_id_o !== 4'd1) begin n_err++; $display("FAIL bp_hold k=%0d v=%b id=%0d want v=1 id=1", k, bus.v_o, bus.grant_id_o); end
      n_vec++; if (bus.yumi_o !== 1'b0) begin n_err++; $display("FAIL bp_yumi k=%0d got %b want 0", k, bus.yumi_o); end
      @(negedge clk_i); #1;
    end
    bus.ready_i = 1'b1; bus.reqs_i = 16'h0004; #1;
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (bus.v_o !== 1'b0 || bus.grants_o !== 16'h0) begin n_err++; $display("FAIL bp_drop k=%0d v=%b grants=%h want v=0 grants=0000", k, bus.v_o, bus.grants_o); end
      @(negedge clk_i); #1;
    end
    bus.reqs_i = 16'h0006; #1;
    // Count resumed at 2, so the forced release lands on the 6th beat from here.
    for (int k = 3; k <= 8; k++) begin
      n_vec++; if (bus.grant_id_o !== 4'd1) begin n_err++; $display("FAIL bp_id beat=%0d got %0d want 1", k, bus.grant_id_o); end
      n_vec++; if (bus.burst_end_o !== (k == 8)) begin n_err++; $display("FAIL bp_end beat=%0d got %b want %b", k, bus.burst_end_o, k == 8); end
      @(negedge clk_i); #1;
    end
    n_vec++; if (bus.grant_id_o !== 4'd2) begin n_err++; $display("FAIL bp_next got %0d want 2", bus.grant_id_o); end
  endtask

  task automatic test_reset_mid_burst();
    reset_then(16'h0006, 16'h0000, 1'b1);
    @(negedge clk_i); #1;
    @(negedge clk_i); #1;   // beat 3 offered, in LOCK
    n_vec++; if (bus.v_o !== 1'b1 || bus.grant_id_o !== 4'd1) begin n_err++; $display("FAIL mid_pre v=%b id=%0d want v=1 id=1", bus.v_o, bus.grant_id_o); end
    reset_i = 1'b1; #1;
    n_vec++; if ({bus.v_o, bus.yumi_o, bus.burst_end_o, bus.grants_o, bus.grant_id_o} !== '0) begin n_err++; $display("FAIL mid_async v=%b yumi=%b end=%b grants=%h id=%0d want all 0", bus.v_o, bus.yumi_o, bus.burst_end_o, bus.grants_o, bus.grant_id_o); end
    @(negedge clk_i);
    bus.reqs_i = 16'h0030; reset_i = 1'b0; #1;
    n_vec++; if (bus.grant_id_o !== 4'd4 || bus.v_o !== 1'b1) begin n_err++; $display("FAIL mid_after id=%0d v=%b want id=4 v=1", bus.grant_id_o, bus.v_o); end
  endtask

  initial begin
    bus.reqs_i = '0; bus.last_i = '0; bus.ready_i = 1'b0;
    test_reset();
    test_rotation();
    test_burst_lock();
    test_forced_release();
    test_backpressure();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
